// File: rtl/slow_clk_pkg.sv
// Shared types and default parameters for the slow clock receiver.
// Used by slow_clk_receiver and its testbench.
package slow_clk_pkg;

    localparam int CNT_W_DEF       = 28;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 200000000;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOST
    } state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Synchronous active-low reset clears every stage.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/slow_clk_receiver.sv
// Measures the rising-to-rising period of a slow asynchronous clock.
// Optional high-time output: define SLOW_CLK_RECEIVER_DUTY_EN.
module slow_clk_receiver
    import slow_clk_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_div_in,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lost
`ifdef SLOW_CLK_RECEIVER_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             sync_out;
    logic             edge_q;
    logic             prev_q;
    logic             rise;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic             tick_q;
    logic             pv_q;
    logic             lost_q;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (clk_div_in),
        .q_o   (sync_out)
    );

    // edge_q is the edge-detect stage; prev_q holds its previous value
    assign rise  = edge_q & ~prev_q;
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_q   <= 1'b0;
            prev_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
            pv_q     <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            edge_q <= sync_out;
            prev_q <= edge_q;
            tick_q <= rise;
            pv_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rise) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        cnt_q    <= '0;
                        period_q <= cnt_d;
                        pv_q     <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= LOST;
                        lost_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                LOST: begin
                    cnt_q <= '0;
                    if (rise) begin
                        state_q <= MEASURE;
                        lost_q  <= 1'b0;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tick         = tick_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign lost         = lost_q;

`ifdef SLOW_CLK_RECEIVER_DUTY_EN
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hcnt_d;
    logic [CNT_W-1:0] high_q;

    assign hcnt_d = hcnt_q + CNT_W'(edge_q);

    // Window matches period: the cycle after one edge through the next edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else if (state_q == MEASURE) begin
            if (rise) begin
                high_q <= hcnt_d;
                hcnt_q <= '0;
            end else begin
                hcnt_q <= hcnt_d;
            end
        end else begin
            hcnt_q <= '0;
        end
    end

    assign high_time = high_q;
`endif

endmodule

// File: tb/tb_slow_clk_receiver.sv
// Self-checking bench for slow_clk_receiver (TIMEOUT=100 and TIMEOUT=20).
// Define SLOW_CLK_RECEIVER_DUTY_EN to also check high_time.
module tb_slow_clk_receiver;

    logic       clk;
    logic       rst_n;
    logic       div0, div1;
    logic       tick0, tick1;
    logic       pv0, pv1;
    logic       lost0, lost1;
    logic [7:0] period0, period1;
`ifdef SLOW_CLK_RECEIVER_DUTY_EN
    logic [7:0] ht0, ht1;
`endif

    int errors = 0;
    int checks = 0;
    int j      = 0;
    int k      = 0;

    slow_clk_receiver #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_div_in   (div0),
        .tick         (tick0),
        .period       (period0),
        .period_valid (pv0),
        .lost         (lost0)
`ifdef SLOW_CLK_RECEIVER_DUTY_EN
        ,
        .high_time    (ht0)
`endif
    );

    slow_clk_receiver #(.CNT_W(8), .SYNC_STAGES(2), .TIMEOUT(20)) dut20 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_div_in   (div1),
        .tick         (tick1),
        .period       (period1),
        .period_valid (pv1),
        .lost         (lost1)
`ifdef SLOW_CLK_RECEIVER_DUTY_EN
        ,
        .high_time    (ht1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Model: a tick is seen 3 cycles after a 0->1 in the sampled input;
    // period is the spacing of consecutive ticks if no longer than TIMEOUT;
    // lost is declared once TIMEOUT cycles pass after a tick with no new one.
    bit zh[2][5];
    bit rh[2][3];
    bit m_tick[2], m_pv[2], m_lost[2], ref_ok[2];
    int last[2], m_per[2], acc[2], m_ht[2];

    task automatic model_step(input int i, input bit in, input bit rst,
                              input int to);
        bit t;
        bit z3;
        for (int n = 4; n > 0; n--) zh[i][n] = zh[i][n-1];
        for (int n = 2; n > 0; n--) rh[i][n] = rh[i][n-1];
        zh[i][0] = rst ? 1'b0 : in;
        rh[i][0] = rst;
        z3 = zh[i][3];
        t  = z3 & ~zh[i][4] & ~rh[i][0] & ~rh[i][1] & ~rh[i][2];
        m_tick[i] = t;
        m_pv[i]   = 1'b0;
        if (rst) begin
            ref_ok[i] = 1'b0;
            m_lost[i] = 1'b0;
            m_per[i]  = 0;
            m_ht[i]   = 0;
            acc[i]    = 0;
        end else if (t) begin
            if (ref_ok[i] && (k - last[i]) <= to) begin
                m_pv[i]  = 1'b1;
                m_per[i] = k - last[i];
                m_ht[i]  = acc[i] + int'(z3);
            end
            acc[i]    = 0;
            m_lost[i] = 1'b0;
            ref_ok[i] = 1'b1;
            last[i]   = k;
        end else if (ref_ok[i]) begin
            acc[i] = acc[i] + int'(z3);
            if ((k - last[i]) >= to) m_lost[i] = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 5; n++) zh[i][n] = 1'b0;
            for (int n = 0; n < 3; n++) rh[i][n] = 1'b1;
            m_tick[i] = 0; m_pv[i] = 0; m_lost[i] = 0; ref_ok[i] = 0;
            last[i] = 0; m_per[i] = 0; acc[i] = 0; m_ht[i] = 0;
        end
    end

    always @(posedge clk) begin
        k++;
        model_step(0, div0, !rst_n, 100);
        model_step(1, div1, !rst_n, 20);
    end

    always @(negedge clk) begin
        if (k > 0) begin
            chk("m_tick0",  tick0,   m_tick[0]);
            chk("m_pv0",    pv0,     m_pv[0]);
            chk("m_lost0",  lost0,   m_lost[0]);
            chk("m_per0",   period0, m_per[0]);
            chk("m_tick1",  tick1,   m_tick[1]);
            chk("m_pv1",    pv1,     m_pv[1]);
            chk("m_lost1",  lost1,   m_lost[1]);
            chk("m_per1",   period1, m_per[1]);
`ifdef SLOW_CLK_RECEIVER_DUTY_EN
            chk("m_ht0",    ht0,     m_ht[0]);
            chk("m_ht1",    ht1,     m_ht[1]);
`endif
        end
    end

    task automatic step(input bit v0, input bit v1);
        div0 = v0;
        div1 = v1;
        @(negedge clk);
        j++;
    endtask

    initial begin
        int r;
        int nt;
        int npv;
        rst_n = 1'b0;
        div0  = 1'b0;
        div1  = 1'b0;
        repeat (3) step(0, 0);
        chk("rst_tick",   tick0,   0);
        chk("rst_pv",     pv0,     0);
        chk("rst_lost",   lost0,   0);
        chk("rst_period", period0, 0);
        rst_n = 1'b1;
        repeat (2) step(0, 0);

        // 16-cycle square wave, three edges, then stop
        j = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                step(c < 8, 0);
                if (j == 3) chk("tick_early", tick0, 0);
                if (j == 4) begin
                    chk("first_tick", tick0, 1);
                    chk("first_nopv", pv0,   0);
                end
                if (j == 20 || j == 36) begin
                    chk("sq_tick", tick0,   1);
                    chk("sq_pv",   pv0,     1);
                    chk("sq_per",  period0, 16);
                end
            end
        end
        while (j < 150) begin
            step(0, 0);
            if (j == 135) chk("lost_early", lost0, 0);
            if (j == 136) begin
                chk("lost_rise",  lost0,   1);
                chk("lost_hold",  period0, 16);
            end
        end

        // restart, then one-cycle reset between edges
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 16; c++) begin
                if (j == 190) rst_n = 1'b0;
                step(c < 8, 0);
                if (j == 153) chk("lost_still", lost0, 1);
                if (j == 154) begin
                    chk("rs_tick", tick0, 1);
                    chk("rs_nopv", pv0,   0);
                    chk("rs_lost", lost0, 0);
                end
                if (j == 170) begin
                    chk("rs_pv",  pv0,     1);
                    chk("rs_per", period0, 16);
                end
                if (j == 191) begin
                    chk("mid_rst_tick", tick0,   0);
                    chk("mid_rst_pv",   pv0,     0);
                    chk("mid_rst_lost", lost0,   0);
                    chk("mid_rst_per",  period0, 0);
                    rst_n = 1'b1;
                end
                if (j == 202) begin
                    chk("pr_tick", tick0, 1);
                    chk("pr_nopv", pv0,   0);
                end
                if (j == 218) begin
                    chk("pr_pv",  pv0,     1);
                    chk("pr_per", period0, 16);
                end
            end
        end

        // input already high when reset is released
        rst_n = 1'b0;
        repeat (3) step(1, 0);
        rst_n = 1'b1;
        r  = j;
        nt = 0;
        for (int n = 0; n < 110; n++) begin
            step(1, 0);
            if (tick0) nt++;
            if (j == r + 4) begin
                chk("hi_tick", tick0, 1);
                chk("hi_nopv", pv0,   0);
            end
            if (j == r + 20)  chk("hi_one_tick", nt, 1);
            if (j == r + 103) chk("hi_lost_early", lost0, 0);
            if (j == r + 104) chk("hi_lost", lost0, 1);
        end

        // TIMEOUT=20 with edges exactly 20 cycles apart
        npv = 0;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 20; c++) begin
                step(1, c < 10);
                chk("t20_lost", lost1, 0);
                if (pv1) begin
                    npv++;
                    chk("t20_per", period1, 20);
                end
            end
        end
        chk("t20_npv", npv, 5);

`ifdef SLOW_CLK_RECEIVER_DUTY_EN
        repeat (4) step(0, 0);
        npv = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 16; c++) begin
                step(c < 5, 0);
                if (pv0) begin
                    npv++;
                    chk("duty_ht",  ht0,     5);
                    chk("duty_per", period0, 16);
                end
            end
        end
        chk("duty_npv", npv, 3);
`endif

        repeat (5) step(0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
